// File: rtl/shot_charge_ctrl.sv
// Shot-power meter: ping-pong power ramp while the debounced button is held, one-cycle shot on release, then cooldown.
// Optional build macro SHOT_AUTOFIRE_EN fires automatically after MAX_HOLD_STEPS power steps.
`timescale 1ns/1ps
module shot_charge_ctrl #(
  parameter int TICK_DIV       = 1_000_000,
  parameter int PWR_W          = 8,
  parameter int PWR_MAX        = 200,
  parameter int COOLDOWN_CYC   = 50_000_000,
  parameter int MAX_HOLD_STEPS = 600
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             btn_db,
  output logic [PWR_W-1:0] power,
  output logic             charging,
  output logic             busy,
  output logic             shot_valid,
  output logic [PWR_W-1:0] shot_power,
  output logic             shot_auto
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CD_W  = $clog2(COOLDOWN_CYC + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN_CYC - 1);
  localparam logic [PWR_W-1:0] P_MAX    = PWR_W'(PWR_MAX);

  if (TICK_DIV < 1 || PWR_MAX < 1 || PWR_MAX >= (1 << PWR_W) ||
      COOLDOWN_CYC < 1 || MAX_HOLD_STEPS < 1) begin : g_param_err
    $error("shot_charge_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, CHARGE, COOLDOWN} state_t;

  state_t           state;
  logic             btn_prev;
  logic             dir_up;
  logic [PRE_W-1:0] pre_cnt;
  logic [CD_W-1:0]  cd_cnt;
  logic             rise;
  logic             fall;
  logic [PWR_W:0]   step_nxt;

  // One ping-pong step; returns {next direction (1 = up), next power}.
  function automatic logic [PWR_W:0] pp_step(input logic [PWR_W-1:0] p, input logic up);
    if (up) begin
      if (p == P_MAX) return {1'b0, P_MAX - PWR_W'(1)};
      else            return {1'b1, p + PWR_W'(1)};
    end else begin
      if (p == '0)    return {1'b1, PWR_W'(1)};
      else            return {1'b0, p - PWR_W'(1)};
    end
  endfunction

  assign rise     = btn_db & ~btn_prev;
  assign fall     = ~btn_db & btn_prev;
  assign step_nxt = pp_step(power, dir_up);
  assign charging = (state == CHARGE);
  assign busy     = (state == COOLDOWN);

`ifdef SHOT_AUTOFIRE_EN
  localparam int HOLD_W = $clog2(MAX_HOLD_STEPS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD_STEPS - 1);
  logic [HOLD_W-1:0] hold_cnt;
`else
  assign shot_auto = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      btn_prev   <= 1'b1;
      dir_up     <= 1'b1;
      pre_cnt    <= '0;
      cd_cnt     <= '0;
      power      <= '0;
      shot_power <= '0;
      shot_valid <= 1'b0;
`ifdef SHOT_AUTOFIRE_EN
      hold_cnt   <= '0;
      shot_auto  <= 1'b0;
`endif
    end else begin
      btn_prev   <= btn_db;
      shot_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise && en) begin
            state   <= CHARGE;
            power   <= '0;
            pre_cnt <= '0;
            dir_up  <= 1'b1;
`ifdef SHOT_AUTOFIRE_EN
            hold_cnt <= '0;
`endif
          end
        end
        CHARGE: begin
          if (!en) begin
            state <= IDLE;
            power <= '0;
          end else if (fall) begin
            // Release fires with the pre-step value even on a step edge.
            shot_power <= power;
            shot_valid <= 1'b1;
`ifdef SHOT_AUTOFIRE_EN
            shot_auto  <= 1'b0;
`endif
            state      <= COOLDOWN;
            cd_cnt     <= '0;
          end else if (pre_cnt == PRE_LAST) begin
            pre_cnt         <= '0;
            {dir_up, power} <= step_nxt;
`ifdef SHOT_AUTOFIRE_EN
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_cnt == HOLD_LAST) begin
              shot_power <= step_nxt[PWR_W-1:0];
              shot_valid <= 1'b1;
              shot_auto  <= 1'b1;
              state      <= COOLDOWN;
              cd_cnt     <= '0;
            end
`endif
          end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
          end
        end
        COOLDOWN: begin
          if (cd_cnt == CD_LAST) begin
            state <= IDLE;
            power <= '0;
          end else begin
            cd_cnt <= cd_cnt + CD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
